// File: rtl/fwd_unit_p.sv
// fwd_unit_p: RAW bypass select and decode stall for the 5-stage pipeline,
// with a retired write-back history and free-running stall/forward counters.
module fwd_unit_p #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int NRP    = 2,
    parameter int HIST   = 2,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRP*REG_AW-1:0] rs_idx,
    input  logic [NRP-1:0]        rs_used,
    input  logic                  ex_wben,
    input  logic [REG_AW-1:0]     ex_rd_idx,
    input  logic                  ex_is_load,
    input  logic                  ls_wben,
    input  logic [REG_AW-1:0]     ls_rd_idx,
    input  logic                  ls_is_load,
    input  logic                  ls_data_vld,
    input  logic                  wb_wben,
    input  logic [REG_AW-1:0]     wb_rd_idx,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    output logic [NRP*SEL_W-1:0]  rs_sel,
    output logic [HIST*XLEN-1:0]  hist_data,
    output logic                  stall_id,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      fwd_cnt
);
    logic              h_vld [HIST];
    logic [REG_AW-1:0] h_idx [HIST];
    logic [XLEN-1:0]   h_dat [HIST];
    logic              stall_raw, any_fwd, ex_hit, ls_hit;
    logic [REG_AW-1:0] s;
    logic [SEL_W-1:0]  sel;

    // Newest producer wins: history scanned oldest-first so younger hits overwrite.
    always_comb begin
        rs_sel    = '0;
        stall_raw = 1'b0;
        any_fwd   = 1'b0;
        ex_hit    = 1'b0;
        ls_hit    = 1'b0;
        s         = '0;
        sel       = '0;
        for (int p = 0; p < NRP; p++) begin
            s      = rs_idx[p*REG_AW +: REG_AW];
            sel    = '0;
            ex_hit = ex_wben && ex_rd_idx == s && ex_rd_idx != '0;
            ls_hit = ls_wben && ls_rd_idx == s && ls_rd_idx != '0;
            if (rs_used[p] && s != '0) begin
                for (int k = HIST - 1; k >= 0; k--)
                    if (h_vld[k] && h_idx[k] == s) sel = SEL_W'(3 + k);
                sel       = ex_hit ? SEL_W'(1) : ls_hit ? SEL_W'(2) : sel;
                stall_raw = stall_raw | (ex_hit & ex_is_load)
                                      | (ls_hit & ls_is_load & ~ls_data_vld);
            end
            rs_sel[p*SEL_W +: SEL_W] = sel;
            any_fwd = any_fwd | (sel != '0);
        end
    end

    assign stall_id = stall_raw & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < HIST; k++) begin
                h_vld[k] <= 1'b0;
                h_idx[k] <= '0;
                h_dat[k] <= '0;
            end
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (wb_wben && wb_rd_idx != '0) begin
                for (int k = HIST - 1; k > 0; k--) begin
                    h_vld[k] <= h_vld[k-1];
                    h_idx[k] <= h_idx[k-1];
                    h_dat[k] <= h_dat[k-1];
                end
                h_vld[0] <= 1'b1;
                h_idx[0] <= wb_rd_idx;
                h_dat[0] <= wb_data;
            end
            if (!flush) begin
                if (stall_id) stall_cnt <= stall_cnt + CNT_W'(1);
                else if (any_fwd) fwd_cnt <= fwd_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < HIST; k++) begin : g_hist
        assign hist_data[k*XLEN +: XLEN] = h_dat[k];
    end
endmodule

// File: tb/tb_fwd_unit_p.sv
// tb_fwd_unit_p: directed and random stimulus against a queue-based reference model.
module tb_fwd_unit_p;
    localparam int XLEN = 64, REG_AW = 5, NRP = 2, HIST = 2, SEL_W = 3, CNT_W = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NRP*REG_AW-1:0] rs_idx = '0;
    logic [NRP-1:0]        rs_used = '0;
    logic                  ex_wben = 0, ex_is_load = 0, ls_wben = 0, ls_is_load = 0;
    logic                  ls_data_vld = 0, wb_wben = 0, flush = 0;
    logic [REG_AW-1:0]     ex_rd_idx = '0, ls_rd_idx = '0, wb_rd_idx = '0;
    logic [XLEN-1:0]       wb_data = '0;
    logic [NRP*SEL_W-1:0]  rs_sel;
    logic [HIST*XLEN-1:0]  hist_data;
    logic                  stall_id;
    logic [CNT_W-1:0]      stall_cnt, fwd_cnt;

    fwd_unit_p #(.XLEN(XLEN), .REG_AW(REG_AW), .NRP(NRP), .HIST(HIST), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .rs_idx(rs_idx), .rs_used(rs_used),
        .ex_wben(ex_wben), .ex_rd_idx(ex_rd_idx), .ex_is_load(ex_is_load),
        .ls_wben(ls_wben), .ls_rd_idx(ls_rd_idx), .ls_is_load(ls_is_load), .ls_data_vld(ls_data_vld),
        .wb_wben(wb_wben), .wb_rd_idx(wb_rd_idx), .wb_data(wb_data), .flush(flush),
        .rs_sel(rs_sel), .hist_data(hist_data), .stall_id(stall_id),
        .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [REG_AW-1:0] idx; logic [XLEN-1:0] data; } wb_t;
    wb_t             hq[$];
    logic [CNT_W-1:0] m_stall, m_fwd;
    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_sel(int p);
        logic [REG_AW-1:0] s = rs_idx[p*REG_AW +: REG_AW];
        if (!rs_used[p] || s == 0) return 0;
        if (ex_wben && ex_rd_idx == s) return 1;
        if (ls_wben && ls_rd_idx == s) return 2;
        foreach (hq[k]) if (hq[k].idx == s) return 3 + k;
        return 0;
    endfunction

    function automatic bit m_stall_id();
        bit st = 0;
        for (int p = 0; p < NRP; p++) begin
            logic [REG_AW-1:0] s = rs_idx[p*REG_AW +: REG_AW];
            if (rs_used[p] && s != 0) begin
                if (ex_wben && ex_rd_idx == s && ex_is_load) st = 1;
                if (ls_wben && ls_rd_idx == s && ls_is_load && !ls_data_vld) st = 1;
            end
        end
        return st && !flush;
    endfunction

    function automatic bit m_any_fwd();
        for (int p = 0; p < NRP; p++) if (m_sel(p) != 0) return 1;
        return 0;
    endfunction

    task automatic check_regs();
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("fwd_cnt", 64'(fwd_cnt), 64'(m_fwd));
        for (int k = 0; k < HIST; k++)
            chk($sformatf("hist_data%0d", k), hist_data[k*XLEN +: XLEN],
                k < hq.size() ? hq[k].data : 64'h0);
    endtask

    // One clock: check at negedge, then advance the model at posedge.
    task automatic cyc();
        @(negedge clk);
        for (int p = 0; p < NRP; p++)
            chk($sformatf("rs_sel%0d", p), 64'(rs_sel[p*SEL_W +: SEL_W]), 64'(m_sel(p)));
        chk("stall_id", 64'(stall_id), 64'(m_stall_id()));
        check_regs();
        @(posedge clk);
        if (!flush) begin
            if (m_stall_id()) m_stall++;
            else if (m_any_fwd()) m_fwd++;
        end
        if (wb_wben && wb_rd_idx != 0) begin
            hq.push_front('{wb_rd_idx, wb_data});
            if (hq.size() > HIST) void'(hq.pop_back());
        end
        #1;
    endtask

    task automatic idle();
        rs_used = '0; rs_idx = '0; ex_wben = 0; ex_is_load = 0; ls_wben = 0; ls_is_load = 0;
        ls_data_vld = 0; wb_wben = 0; flush = 0; ex_rd_idx = '0; ls_rd_idx = '0; wb_rd_idx = '0;
    endtask

    task automatic rd(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b, input logic [1:0] u);
        rs_idx = {b, a}; rs_used = u;
    endtask

    task automatic wb(input logic [REG_AW-1:0] r, input logic [XLEN-1:0] d);
        wb_wben = 1; wb_rd_idx = r; wb_data = d;
    endtask

    task automatic rand_cyc();
        rs_idx = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        rs_used = 2'($urandom);
        ex_wben = 1'($urandom); ex_rd_idx = 5'($urandom_range(0, 7)); ex_is_load = 1'($urandom);
        ls_wben = 1'($urandom); ls_rd_idx = 5'($urandom_range(0, 7)); ls_is_load = 1'($urandom);
        ls_data_vld = 1'($urandom);
        wb_wben = 1'($urandom); wb_rd_idx = 5'($urandom_range(0, 7)); wb_data = {$urandom, $urandom};
        flush = ($urandom_range(0, 7) == 0);
        cyc();
    endtask

    initial begin
        m_stall = '0; m_fwd = '0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        cyc();
        // ALU chain
        ex_wben = 1; ex_rd_idx = 5; rd(5, 0, 2'b01); cyc();
        chk("alu_fwd_cnt", 64'(fwd_cnt), 64'd1);
        // Load-use, then load data ready in LS
        idle(); ex_wben = 1; ex_is_load = 1; ex_rd_idx = 7; rd(0, 7, 2'b10); cyc();
        chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
        idle(); ls_wben = 1; ls_is_load = 1; ls_rd_idx = 7; ls_data_vld = 1; rd(0, 7, 2'b10); cyc();
        chk("lu_fwd_cnt", 64'(fwd_cnt), 64'd2);
        // Memory wait
        idle(); ls_wben = 1; ls_is_load = 1; ls_rd_idx = 9; rd(9, 0, 2'b01);
        repeat (3) cyc();
        chk("mw_stall_cnt", 64'(stall_cnt), 64'd4);
        ls_data_vld = 1; cyc();
        chk("mw_fwd_cnt", 64'(fwd_cnt), 64'd3);
        // History fill, lookup, eviction
        idle(); wb(3, 64'hA); cyc();
        wb(4, 64'hB); cyc();
        wb_wben = 0; rd(3, 4, 2'b11); cyc();
        chk("hist1_data", hist_data[XLEN +: XLEN], 64'hA);
        wb(5, 64'hC); rd(0, 0, 2'b00); cyc();
        wb_wben = 0; rd(3, 0, 2'b01); cyc();
        // x0 and priority
        idle(); ex_wben = 1; ex_rd_idx = 0; rd(0, 0, 2'b11); cyc();
        wb(6, 64'h66); cyc();
        wb_wben = 0; ex_wben = 1; ex_rd_idx = 6; ls_wben = 1; ls_rd_idx = 6; rd(6, 6, 2'b11); cyc();
        rd(6, 6, 2'b00); cyc();
        // Flush suppresses a load-use stall and counting
        idle(); ex_wben = 1; ex_is_load = 1; ex_rd_idx = 7; rd(7, 0, 2'b01); flush = 1; cyc();
        idle();
        repeat (300) rand_cyc();
        // Asynchronous reset mid-run
        idle(); wb(3, 64'h33); cyc();
        wb_wben = 0;
        #2 rst_n = 1'b0;
        #1;
        hq.delete(); m_stall = '0; m_fwd = '0;
        check_regs();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        rd(3, 0, 2'b01); cyc();
        repeat (200) rand_cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
